// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//   Registered, handshaked RISC-V instruction-decode pipeline stage sitting
//   between fetch and register-read/execute. The incoming 32-bit instruction
//   is decoded combinationally (fields, format class, sign-extended
//   immediate, optional illegal flag) and the result is captured together
//   with the fetch PC. An output register plus a skid register give full
//   throughput under backpressure while in_ready depends only on
//   registered state.
//
//   Optional feature (compile-time macro):
//     DECODE_ILLEGAL_EN - when defined, out_illegal flags malformed or
//                         unsupported encodings; when undefined out_illegal
//                         is tied low and no checking logic exists.
//
//   Parameters:
//     XLEN  - datapath width (32 or 64): imm width, RV64 opcode acceptance
//     PC_W  - width of the pc passthrough
//
//   Ports:
//     clk, rst_n          clock (rising edge), async active-low reset
//     flush               synchronous flush, discards held and incoming data
//     in_valid/in_ready   fetch-side handshake
//     in_instr, in_pc     instruction word and its address
//     out_valid/out_ready downstream handshake
//     out_opcode..funct7  raw instruction fields
//     out_imm             XLEN-wide sign-extended immediate
//     out_itype           format: R=0 I=1 S=2 B=3 U=4 J=5 none=7
//     out_pc              pc of the decoded instruction
//     out_illegal         illegal-instruction flag
// ---------------------------------------------------------------------------
module decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_itype,
  output logic [PC_W-1:0] out_pc,
  output logic            out_illegal
);

  localparam logic [2:0] IT_R    = 3'd0;
  localparam logic [2:0] IT_I    = 3'd1;
  localparam logic [2:0] IT_S    = 3'd2;
  localparam logic [2:0] IT_B    = 3'd3;
  localparam logic [2:0] IT_U    = 3'd4;
  localparam logic [2:0] IT_J    = 3'd5;
  localparam logic [2:0] IT_NONE = 3'd7;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // The raw instruction is kept whole; the field outputs are slices of it.
  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    logic [2:0]      itype;
    logic [PC_W-1:0] pc;
    logic            illegal;
  } bundle_t;

  localparam bundle_t RESET_BUNDLE = '{
    instr:   32'd0,
    imm:     {XLEN{1'b0}},
    itype:   IT_NONE,
    pc:      {PC_W{1'b0}},
    illegal: 1'b0
  };

  state_t  state_q, state_d;
  bundle_t out_q, out_d;
  bundle_t skid_q, skid_d;
  logic    out_valid_q, out_valid_d;
  logic    in_ready_q, in_ready_d;

  logic [6:0]        opc;
  logic [2:0]        dec_itype;
  logic signed [31:0] imm32;
  logic              dec_illegal;
  bundle_t           dec_bundle;
  logic              accept;
  logic              drain;

  assign opc = in_instr[6:0];

  // Format classification and 32-bit immediate assembly.
  always_comb begin
    dec_itype = IT_NONE;
    imm32     = 32'sd0;
    case (opc)
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
        dec_itype = IT_I;
        imm32     = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0100011: begin
        dec_itype = IT_S;
        imm32     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec_itype = IT_B;
        imm32     = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_itype = IT_U;
        imm32     = {in_instr[31:12], 12'd0};
      end
      7'b1101111: begin
        dec_itype = IT_J;
        imm32     = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b0110011: begin
        dec_itype = IT_R;
        imm32     = 32'sd0;
      end
      // OP-IMM-32 / OP-32 exist only on RV64.
      7'b0011011: begin
        dec_itype = (XLEN == 64) ? IT_I : IT_NONE;
        imm32     = (XLEN == 64) ? {{20{in_instr[31]}}, in_instr[31:20]} : 32'sd0;
      end
      7'b0111011: begin
        dec_itype = (XLEN == 64) ? IT_R : IT_NONE;
        imm32     = 32'sd0;
      end
      default: begin
        dec_itype = IT_NONE;
        imm32     = 32'sd0;
      end
    endcase
  end

`ifdef DECODE_ILLEGAL_EN
  logic [2:0] f3;
  logic [6:0] f7;
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];

  // Illegal-encoding detection on top of the format class.
  always_comb begin
    dec_illegal = (in_instr[1:0] != 2'b11) || (dec_itype == IT_NONE);
    case (opc)
      7'b0110011, 7'b0111011:
        dec_illegal = dec_illegal ||
                      !((f7 == 7'b0000000) || (f7 == 7'b0100000) || (f7 == 7'b0000001));
      7'b1100111:
        dec_illegal = dec_illegal || (f3 != 3'b000);
      7'b1100011:
        dec_illegal = dec_illegal || (f3 == 3'b010) || (f3 == 3'b011);
      7'b0000011:
        dec_illegal = dec_illegal || (f3 == 3'b111) ||
                      ((XLEN == 32) && ((f3 == 3'b011) || (f3 == 3'b110)));
      7'b0100011:
        dec_illegal = dec_illegal || f3[2] || ((XLEN == 32) && (f3 == 3'b011));
      default:
        dec_illegal = dec_illegal;
    endcase
  end
`else
  assign dec_illegal = 1'b0;
`endif

  // Sign extension from bit 31 covers both XLEN=32 and XLEN=64.
  assign dec_bundle = '{
    instr:   in_instr,
    imm:     XLEN'(imm32),
    itype:   dec_itype,
    pc:      in_pc,
    illegal: dec_illegal
  };

  assign accept = in_valid && in_ready_q;
  assign drain  = out_valid_q && out_ready;

  // Skid-buffer next-state; flush overrides every transfer.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            out_d   = dec_bundle;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            state_d = ST_ONE;
            out_d   = dec_bundle;
          end else if (accept) begin
            state_d = ST_TWO;
            skid_d  = dec_bundle;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          if (drain) begin
            state_d = ST_ONE;
            out_d   = skid_q;
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_TWO);
  end

  // State, data and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      out_q       <= RESET_BUNDLE;
      skid_q      <= RESET_BUNDLE;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_opcode  = out_q.instr[6:0];
  assign out_rd      = out_q.instr[11:7];
  assign out_funct3  = out_q.instr[14:12];
  assign out_rs1     = out_q.instr[19:15];
  assign out_rs2     = out_q.instr[24:20];
  assign out_funct7  = out_q.instr[31:25];
  assign out_imm     = out_q.imm;
  assign out_itype   = out_q.itype;
  assign out_pc      = out_q.pc;
  assign out_illegal = out_q.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked instruction-decode pipeline stage placed between fetch and register-read/execute.
- Splits a 32-bit RISC-V base instruction into fields and generates an XLEN-wide sign-extended immediate.
- Classifies the instruction format and carries the fetch PC alongside.
- A 2-entry skid buffer gives full throughput under backpressure. Supports synchronous flush for branch redirect.

Parameters:
- XLEN, 32, datapath width. 32 or 64; sets imm/pc width and RV64 opcode acceptance.
- PC_W, XLEN, width of the pc passthrough.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous pipeline flush
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  stage can accept
- in_instr  input  32  instruction word
- in_pc  input  PC_W  instruction address
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  downstream accepts
- out_opcode  output  7  instr[6:0]
- out_rd  output  5  instr[11:7]
- out_funct3  output  3  instr[14:12]
- out_rs1  output  5  instr[19:15]
- out_rs2  output  5  instr[24:20]
- out_funct7  output  7  instr[31:25]
- out_imm  output  XLEN  sign-extended immediate
- out_itype  output  3  format: R=0, I=1, S=2, B=3, U=4, J=5, none=7
- out_pc  output  PC_W  pc of the decoded instruction
- out_illegal  output  1  illegal-instruction flag

Behaviour:
- Reset (async, rst_n=0):
  - state EMPTY; out_valid=0; in_ready=1.
  - All out_* data outputs = 0, except out_itype=7.
- Handshakes:
  - Input transfer occurs when in_valid&in_ready.
  - Output transfer occurs when out_valid&out_ready.
  - Latency: an accepted instruction appears on the outputs on the next rising edge.
  - Order is preserved. No bundle is dropped or duplicated except on flush.
- Storage: output register (OUT) plus skid register (SKID). Decode is done combinationally on in_instr and the registered result is stored.
- States:
  - EMPTY: OUT and SKID empty.
  - ONE: OUT valid.
  - TWO: OUT and SKID valid.
- in_ready = (state != TWO). It is a registered-state function and does not depend combinationally on out_ready.
- Transitions (ignoring flush):
  - EMPTY: accept -> ONE.
  - ONE:
    - accept & drain -> ONE, OUT loads the new bundle.
    - accept & !drain -> TWO, SKID loads the new bundle.
    - drain only -> EMPTY.
  - TWO:
    - drain -> ONE, OUT <= SKID.
    - otherwise hold.
- flush=1 at an edge:
  - next state EMPTY; out_valid=0 next cycle.
  - The input presented that cycle is discarded even if in_ready=1.
  - flush has priority over every transfer. An output transfer in the flush cycle still counts downstream.
- out_* data are stable while out_valid=1 and out_ready=0.
- Immediate (bits then sign-extended from instr[31] to XLEN):
  - I (0010011, 0000011, 1100111, 1110011, 0001111): instr[31:20].
  - S (0100011): instr[31:25], instr[11:7].
  - B (1100011): instr[31], instr[7], instr[30:25], instr[11:8], 0.
  - U (0110111, 0010111): instr[31:12], 12'b0. When XLEN=64, sign-extend from bit 31.
  - J (1101111): instr[31], instr[19:12], instr[20], instr[30:21], 0.
  - R (0110011): imm=0.
  - Unknown: imm=0, itype=7.
- XLEN=64 only: 0011011 is itype I, and 0111011 is itype R.
- XLEN=32: the opcodes 0011011 and 0111011 are unknown (itype 7).

Optional Feature:
- Macro: DECODE_ILLEGAL_EN.
- Defined: out_illegal=1 when any of the following holds:
  - instr[1:0] != 2'b11.
  - itype=7.
  - R-type with funct7 not in {0000000, 0100000, 0000001}.
  - JALR with funct3 != 000.
  - Branch with funct3 in {010, 011}.
  - Load with funct3=111. For XLEN=32, load funct3 011 and 110 are also illegal.
  - Store with funct3 >= 100. For XLEN=32, store funct3 011 is also illegal.
  - Illegal bundles still flow through the handshake normally.
- Undefined: out_illegal is constant 0. No checking logic is synthesised.

Test Plan:
- Reset, then in_instr=0xFFF00093, in_pc=0x100, in_valid=1 for one cycle with out_ready=1 -> next cycle:
  - out_valid=1, rd=1, rs1=0, funct3=0.
  - imm=0xFFFFFFFF, itype=1, pc=0x100, illegal=0.
- in_instr=0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, itype=3.
- Backpressure, with out_ready=0 and three back-to-back inputs A, B, C:
  - After A and B, in_ready=0 and C is held.
  - Raise out_ready -> outputs A, B, C on consecutive cycles, with no loss.
- State TWO, then flush=1 with in_valid=1 -> next cycle out_valid=0 and in_ready=1. The flush-cycle input never appears on the outputs.
- rst_n pulsed low asynchronously mid-stream while in TWO -> outputs clear immediately: out_valid=0, itype=7, in_ready=1.
- XLEN=64 with in_instr=0x800000B7 -> imm=0xFFFFFFFF80000000.
- With DECODE_ILLEGAL_EN: in_instr=0x00000000 -> out_illegal=1.
- Without DECODE_ILLEGAL_EN: in_instr=0x00000000 -> out_illegal=0, out_valid=1.
